// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU control path: scoreboard entry states and the
// control <-> writeback vectors, sized for the XIF instruction-ID space.
package fir_xifu_pkg;

  localparam int unsigned XifNid     = 16;
  localparam int unsigned XifIdWidth = $clog2(XifNid);

  typedef enum logic [1:0] {
    SbIdle      = 2'd0,
    SbIssued    = 2'd1,
    SbCommitted = 2'd2,
    SbKilled    = 2'd3
  } sb_state_t;

  typedef struct packed {
    logic [XifNid-1:0] issue;
    logic [XifNid-1:0] commit;
    logic [XifNid-1:0] kill;
  } ctrl2wb_t;

  typedef struct packed {
    logic [XifNid-1:0] clear;
  } wb2ctrl_t;

endpackage

// File: rtl/fir_xifu_sb_entry.sv
// Lifecycle FSM for a single XIF instruction ID. Protocol checks are built only
// when FIR_XIFU_SB_ERR_EN is defined; otherwise err is tied low.
module fir_xifu_sb_entry
  import fir_xifu_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      issue,
  input  logic      commit,
  input  logic      kill,
  input  logic      clear,
  input  logic      flush,
  output sb_state_t state,
  output logic      err
);

  sb_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (issue) begin
      // A reused ID restarts regardless of any retirement in the same cycle
      state_d = SbIssued;
    end else begin
      case (state_q)
        SbIssued:    if (commit) state_d = kill ? SbKilled : SbCommitted;
        SbCommitted: if (clear) state_d = SbIdle;
        SbKilled:    if (clear || flush) state_d = SbIdle;
        default:     state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SbIdle;
    else         state_q <= state_d;
  end

  assign state = state_q;

`ifdef FIR_XIFU_SB_ERR_EN
  logic retiring;
  assign retiring = ((state_q == SbCommitted) && clear) ||
                    ((state_q == SbKilled) && (clear || flush));
  assign err = (issue && (state_q != SbIdle) && !retiring) ||
               (commit && (state_q != SbIssued)) ||
               (clear && ((state_q == SbIdle) || (state_q == SbIssued)));
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/fir_xifu_scoreboard.sv
// Per-ID scoreboard and issue throttle for the FIR XIFU coprocessor.
// Optional sticky protocol-error detection under FIR_XIFU_SB_ERR_EN.
module fir_xifu_scoreboard
  import fir_xifu_pkg::*;
#(
  parameter int unsigned NID          = XifNid,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   issue_accept_i,
  input  logic [$clog2(NID)-1:0] issue_id_i,
  output logic                   issue_ready_o,
  input  logic                   commit_valid_i,
  input  logic [$clog2(NID)-1:0] commit_id_i,
  input  logic                   commit_kill_i,
  input  logic [NID-1:0]         clear_i,
  input  logic                   flush_i,
  output ctrl2wb_t               ctrl2wb_o,
  output logic [$clog2(NID+1)-1:0] inflight_o,
  output logic                   error_o
);

  localparam int unsigned IdW  = $clog2(NID);
  localparam int unsigned CntW = $clog2(NID + 1);

  sb_state_t        state [NID];
  logic [NID-1:0]   entry_err;
  logic [CntW-1:0]  busy_cnt;

  for (genvar i = 0; i < NID; i++) begin : g_entry
    fir_xifu_sb_entry u_entry (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .issue  (issue_accept_i && (issue_id_i == IdW'(i))),
      .commit (commit_valid_i && (commit_id_i == IdW'(i))),
      .kill   (commit_kill_i),
      .clear  (clear_i[i]),
      .flush  (flush_i),
      .state  (state[i]),
      .err    (entry_err[i])
    );
  end

  // Outputs are decoded from registered entry states only
  always_comb begin
    ctrl2wb_o = '0;
    busy_cnt  = '0;
    for (int i = 0; i < NID; i++) begin
      ctrl2wb_o.issue[i]  = (state[i] != SbIdle);
      ctrl2wb_o.commit[i] = (state[i] == SbCommitted) || (state[i] == SbKilled);
      ctrl2wb_o.kill[i]   = (state[i] == SbKilled);
      busy_cnt            = busy_cnt + CntW'(state[i] != SbIdle);
    end
  end

  assign inflight_o    = busy_cnt;
  assign issue_ready_o = (busy_cnt < CntW'(MAX_INFLIGHT));

`ifdef FIR_XIFU_SB_ERR_EN
  logic error_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      error_q <= 1'b0;
    end else if ((|entry_err) || (issue_accept_i && !issue_ready_o)) begin
      error_q <= 1'b1;
    end
  end

  assign error_o = error_q;
`else
  logic unused_entry_err;
  assign unused_entry_err = |entry_err;
  assign error_o          = 1'b0;
`endif

endmodule

// File: tb/tb_fir_xifu_scoreboard.sv
// Scoreboard bench for fir_xifu_scoreboard: a behavioural per-ID model queues the
// expected outputs for every driven cycle; each test pops and compares them.
module tb_fir_xifu_scoreboard;
  import fir_xifu_pkg::*;

  typedef struct packed {
    ctrl2wb_t   c;
    logic [4:0] inf;
    logic       rdy;
    logic       err;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_accept_i;
  logic [3:0]  issue_id_i;
  logic        issue_ready_o;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic [15:0] clear_i;
  logic        flush_i;
  ctrl2wb_t    ctrl2wb_o;
  logic [4:0]  inflight_o;
  logic        error_o;

  int unsigned nchk = 0;
  int unsigned nfail = 0;

  sb_state_t m [16];
  logic      merr;
  exp_t      sbq [$];
  exp_t      e;

  always #5 clk_i = ~clk_i;

  fir_xifu_scoreboard #(
    .NID          (16),
    .MAX_INFLIGHT (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .issue_accept_i (issue_accept_i),
    .issue_id_i     (issue_id_i),
    .issue_ready_o  (issue_ready_o),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .clear_i        (clear_i),
    .flush_i        (flush_i),
    .ctrl2wb_o      (ctrl2wb_o),
    .inflight_o     (inflight_o),
    .error_o        (error_o)
  );

  function automatic exp_t dut_out();
    return exp_t'({ctrl2wb_o, inflight_o, issue_ready_o, error_o});
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < 16; i++) if (m[i] != SbIdle) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = SbIdle;
    merr = 1'b0;
    sbq.delete();
  endtask

  task automatic idle_inputs();
    issue_accept_i = 1'b0;
    issue_id_i     = '0;
    commit_valid_i = 1'b0;
    commit_id_i    = '0;
    commit_kill_i  = 1'b0;
    clear_i        = '0;
    flush_i        = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model, queue the expected outputs.
  task automatic drive(input logic acc, input logic [3:0] iid, input logic cv,
                       input logic [3:0] cid, input logic ck, input logic [15:0] clr,
                       input logic fl);
    sb_state_t nxt [16];
    exp_t      x;
    logic      bad;
    int        n;
    issue_accept_i = acc; issue_id_i = iid;
    commit_valid_i = cv;  commit_id_i = cid; commit_kill_i = ck;
    clear_i = clr; flush_i = fl;
    bad = acc && (busy_count() >= 4);
    for (int i = 0; i < 16; i++) begin
      logic isu, cmt, ret;
      isu = acc && (iid == 4'(i));
      cmt = cv && (cid == 4'(i));
      ret = (m[i] == SbCommitted && clr[i]) || (m[i] == SbKilled && (clr[i] || fl));
      nxt[i] = m[i];
      if (cmt && m[i] != SbIssued) bad = 1'b1;
      if (clr[i] && (m[i] == SbIdle || m[i] == SbIssued)) bad = 1'b1;
      if (isu) begin
        if (m[i] != SbIdle && !ret) bad = 1'b1;
        nxt[i] = SbIssued;
      end else if (cmt && m[i] == SbIssued) begin
        nxt[i] = ck ? SbKilled : SbCommitted;
      end else if (ret) begin
        nxt[i] = SbIdle;
      end
    end
`ifdef FIR_XIFU_SB_ERR_EN
    merr = merr | bad;
`endif
    x = '0;
    for (int i = 0; i < 16; i++) begin
      m[i] = nxt[i];
      x.c.issue[i]  = (m[i] != SbIdle);
      x.c.commit[i] = (m[i] == SbCommitted || m[i] == SbKilled);
      x.c.kill[i]   = (m[i] == SbKilled);
    end
    n     = busy_count();
    x.inf = 5'(n);
    x.rdy = (n < 4);
    x.err = merr;
    sbq.push_back(x);
    @(posedge clk_i);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    exp_t rv;
    idle_inputs();
    rst_ni = 1'b0;
    model_reset();
    #3;
    rv = '0; rv.rdy = 1'b1;
    nchk++;
    if (dut_out() !== rv) begin
      nfail++; $display("FAIL reset_state got=%h exp=%h", dut_out(), rv);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_issue();
    drive(1, 3, 0, 0, 0, '0, 0);
    e = sbq.pop_front(); nchk++;
    if (dut_out() !== e) begin nfail++; $display("FAIL issue3 got=%h exp=%h", dut_out(), e); end
    nchk++;
    if (ctrl2wb_o.issue[3] !== 1'b1 || inflight_o !== 5'd1 || ctrl2wb_o.commit !== '0 ||
        ctrl2wb_o.kill !== '0) begin
      nfail++; $display("FAIL issue3_fields got=%h/%0d exp=issue[3]=1,inflight=1",
                        ctrl2wb_o, inflight_o);
    end
  endtask

  task automatic test_commit_clear();
    drive(0, 0, 1, 3, 0, '0, 0);
    e = sbq.pop_front(); nchk++;
    if (dut_out() !== e) begin nfail++; $display("FAIL commit3 got=%h exp=%h", dut_out(), e); end
    nchk++;
    if (ctrl2wb_o.commit[3] !== 1'b1 || ctrl2wb_o.kill[3] !== 1'b0) begin
      nfail++; $display("FAIL commit3_bit got=%b exp=1", ctrl2wb_o.commit[3]);
    end
    drive(0, 0, 0, 0, 0, 16'h0008, 0);
    e = sbq.pop_front(); nchk++;
    if (dut_out() !== e) begin nfail++; $display("FAIL clear3 got=%h exp=%h", dut_out(), e); end
    nchk++;
    if (ctrl2wb_o.issue[3] !== 1'b0 || inflight_o !== 5'd0) begin
      nfail++; $display("FAIL clear3_idle got=%b/%0d exp=0/0", ctrl2wb_o.issue[3], inflight_o);
    end
  endtask

  task automatic test_throttle();
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'(i), 0, 0, 0, '0, 0);
      e = sbq.pop_front(); nchk++;
      if (dut_out() !== e) begin
        nfail++; $display("FAIL throttle_issue%0d got=%h exp=%h", i, dut_out(), e);
      end
    end
    nchk++;
    if (issue_ready_o !== 1'b0 || inflight_o !== 5'd4) begin
      nfail++; $display("FAIL throttle_full got=%b/%0d exp=0/4", issue_ready_o, inflight_o);
    end
    drive(0, 0, 1, 1, 0, '0, 0);
    e = sbq.pop_front(); nchk++;
    if (dut_out() !== e) begin nfail++; $display("FAIL commit1 got=%h exp=%h", dut_out(), e); end
    drive(0, 0, 0, 0, 0, 16'h0002, 0);
    e = sbq.pop_front(); nchk++;
    if (issue_ready_o !== 1'b1 || inflight_o !== 5'd3 || dut_out() !== e) begin
      nfail++; $display("FAIL throttle_reopen got=%h exp=%h", dut_out(), e);
    end
    // Retire 0, 2, 3 so the next scenario starts empty
    for (int i = 0; i < 4; i++) begin
      if (i == 1) continue;
      drive(0, 0, 1, 4'(i), 0, '0, 0);
      e = sbq.pop_front(); nchk++;
      if (dut_out() !== e) begin
        nfail++; $display("FAIL drain_commit%0d got=%h exp=%h", i, dut_out(), e);
      end
      drive(0, 0, 0, 0, 0, 16'(1 << i), 0);
      e = sbq.pop_front(); nchk++;
      if (dut_out() !== e) begin
        nfail++; $display("FAIL drain_clear%0d got=%h exp=%h", i, dut_out(), e);
      end
    end
  endtask

  task automatic test_kill_flush();
    drive(1, 5, 0, 0, 0, '0, 0);
    e = sbq.pop_front();
    drive(1, 6, 0, 0, 0, '0, 0);
    e = sbq.pop_front(); nchk++;
    if (dut_out() !== e) begin nfail++; $display("FAIL issue56 got=%h exp=%h", dut_out(), e); end
    drive(0, 0, 1, 5, 1, '0, 0);
    e = sbq.pop_front(); nchk++;
    if (ctrl2wb_o.kill[5] !== 1'b1 || ctrl2wb_o.commit[5] !== 1'b1 || dut_out() !== e) begin
      nfail++; $display("FAIL kill5 got=%h exp=%h", dut_out(), e);
    end
    drive(0, 0, 0, 0, 0, '0, 1);
    e = sbq.pop_front(); nchk++;
    if (ctrl2wb_o.issue[5] !== 1'b0 || ctrl2wb_o.issue[6] !== 1'b1 || inflight_o !== 5'd1 ||
        dut_out() !== e) begin
      nfail++; $display("FAIL flush got=%h exp=%h", dut_out(), e);
    end
    drive(0, 0, 1, 6, 0, '0, 0);
    e = sbq.pop_front();
    drive(0, 0, 0, 0, 0, 16'h0040, 0);
    e = sbq.pop_front(); nchk++;
    if (dut_out() !== e) begin nfail++; $display("FAIL retire6 got=%h exp=%h", dut_out(), e); end
  endtask

  task automatic test_back_to_back_reissue();
    drive(1, 2, 0, 0, 0, '0, 0);
    e = sbq.pop_front();
    drive(0, 0, 1, 2, 0, '0, 0);
    e = sbq.pop_front(); nchk++;
    if (ctrl2wb_o.commit[2] !== 1'b1 || dut_out() !== e) begin
      nfail++; $display("FAIL commit2 got=%h exp=%h", dut_out(), e);
    end
    drive(1, 2, 0, 0, 0, 16'h0004, 0);
    e = sbq.pop_front(); nchk++;
    if (ctrl2wb_o.issue[2] !== 1'b1 || ctrl2wb_o.commit[2] !== 1'b0 || inflight_o !== 5'd1 ||
        error_o !== 1'b0 || dut_out() !== e) begin
      nfail++; $display("FAIL reissue2 got=%h exp=%h", dut_out(), e);
    end
  endtask

  task automatic test_error();
    exp_t rv;
    drive(0, 0, 1, 9, 0, '0, 0);
    e = sbq.pop_front(); nchk++;
    if (ctrl2wb_o.issue[9] !== 1'b0 || dut_out() !== e) begin
      nfail++; $display("FAIL commit_idle9 got=%h exp=%h", dut_out(), e);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, '0, 0);
      e = sbq.pop_front(); nchk++;
      if (dut_out() !== e) begin
        nfail++; $display("FAIL error_hold%0d got=%h exp=%h", i, dut_out(), e);
      end
    end
    rst_ni = 1'b0;
    model_reset();
    #1;
    rv = '0; rv.rdy = 1'b1;
    nchk++;
    if (dut_out() !== rv) begin
      nfail++; $display("FAIL error_reset got=%h exp=%h", dut_out(), rv);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_random();
    exp_t rv;
    for (int k = 0; k < 80; k++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom),
            1'($urandom_range(0, 1)), 16'($urandom & $urandom), ($urandom_range(0, 9) == 0));
      e = sbq.pop_front(); nchk++;
      if (dut_out() !== e) begin
        nfail++; $display("FAIL random%0d got=%h exp=%h", k, dut_out(), e);
      end
    end
    // Asynchronous reset mid-cycle must clear everything without a clock edge
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    rv = '0; rv.rdy = 1'b1;
    nchk++;
    if (dut_out() !== rv) begin
      nfail++; $display("FAIL async_reset got=%h exp=%h", dut_out(), rv);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_issue();
    test_commit_clear();
    test_throttle();
    test_kill_flush();
    test_back_to_back_reissue();
    test_error();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
